// File: rtl/dcache_req_enq_arbiter.sv
// Round-robin enqueue arbiter: N_REQ D-cache requesters share one branch-killable
// queue through a one-entry staging register with reservation and anti-starvation.
package ExuST;
  localparam int MAX_BR_COUNT = 4;

  typedef struct packed {
    logic [MAX_BR_COUNT-1:0] resolve_mask;
  } BrResolutionInfoST;

  typedef struct packed {
    BrResolutionInfoST b1;
  } BrUpdateInfoST;
endpackage

package MSHRST;
  typedef struct packed {
    logic [ExuST::MAX_BR_COUNT-1:0] br_mask;
    logic                           uses_ldq;
    logic                           uses_stq;
    logic [4:0]                     ldq_idx;
    logic [4:0]                     stq_idx;
  } MicroOpST;

  typedef struct packed {
    MicroOpST    uop;
    logic [4:0]  cmd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } BoomDCacheReqInternalST;
endpackage

// Handshakes: a transfer happens in a cycle where valid and ready are both 1;
// ready never depends on the same port's ready, and valid never waits on ready.
module dcache_req_enq_arbiter #(
  parameter int N_REQ        = 3,
  parameter int Q_ENTRIES    = 16,
  parameter int RESERVE      = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                               clock,
  input  logic                               reset,
  input  ExuST::BrUpdateInfoST               io_brupdate,
  input  logic                               io_flush,
  input  logic [N_REQ-1:0]                   io_req_valid,
  output logic [N_REQ-1:0]                   io_req_ready,
  input  MSHRST::BoomDCacheReqInternalST     io_req_bits [N_REQ],
  output logic                               io_enq_valid,
  input  logic                               io_enq_ready,
  output MSHRST::BoomDCacheReqInternalST     io_enq_bits,
  input  logic [$clog2(Q_ENTRIES):0]         io_q_count,
  output logic [$clog2(N_REQ)-1:0]           io_grant_id,
  output logic                               io_busy
);
  localparam int BRW = ExuST::MAX_BR_COUNT;
  localparam int GW  = $clog2(N_REQ);
  localparam int CW  = $clog2(Q_ENTRIES) + 1;
  localparam int WW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] SHARED_LIMIT = CW'(Q_ENTRIES - RESERVE);
  localparam logic [WW-1:0] WAIT_MAX     = WW'(STARVE_LIMIT);
  localparam logic [GW-1:0] LAST_ID      = GW'(N_REQ - 1);

  typedef MSHRST::BoomDCacheReqInternalST req_t;

  function automatic logic killed(input logic [BRW-1:0] m, input logic [BRW-1:0] r);
    return |(m & r);
  endfunction

  logic [BRW-1:0] resolve;
  logic [N_REQ-1:0] elig;
  logic           stage_valid;
  logic [GW-1:0]  stage_id;
  req_t           stage_bits;
  logic [GW-1:0]  rr_ptr;
  logic [WW-1:0]  wait_cnt [N_REQ];
  logic           stage_dead;
  logic           stage_free;
  logic           win_valid;
  logic           win_starve;
  logic [GW-1:0]  win_id;
  req_t           win_bits;

  assign resolve = io_brupdate.b1.resolve_mask;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = io_req_valid[i]
             && !killed(io_req_bits[i].uop.br_mask, resolve)
             && !(io_flush && io_req_bits[i].uop.uses_ldq)
             && ((i == 0) || (io_q_count < SHARED_LIMIT));
    end
  end

  assign stage_dead = stage_valid
                   && (killed(stage_bits.uop.br_mask, resolve)
                       || (io_flush && stage_bits.uop.uses_ldq));
  assign stage_free = !stage_valid || io_enq_ready || stage_dead;

  // Loops run downward so the last hit is the lowest index / nearest to rr_ptr.
  always_comb begin
    int idx;
    idx        = 0;
    win_valid  = 1'b0;
    win_starve = 1'b0;
    win_id     = '0;
    win_bits   = '0;
    if (stage_free) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (elig[i] && (wait_cnt[i] == WAIT_MAX)) begin
          win_valid  = 1'b1;
          win_starve = 1'b1;
          win_id     = GW'(i);
        end
      end
      if (!win_starve) begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          idx = int'(rr_ptr) + k;
          if (idx >= N_REQ) idx = idx - N_REQ;
          if (elig[idx]) begin
            win_valid = 1'b1;
            win_id    = GW'(idx);
          end
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == GW'(i)) win_bits = io_req_bits[i];
    end
  end

  always_comb begin
    io_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      io_req_ready[i] = win_valid && (win_id == GW'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_id    <= '0;
      stage_bits  <= '0;
      rr_ptr      <= '0;
    end else begin
      if (win_valid) begin
        stage_valid              <= 1'b1;
        stage_id                 <= win_id;
        stage_bits               <= win_bits;
        stage_bits.uop.br_mask   <= win_bits.uop.br_mask & ~resolve;
        if (!win_starve) rr_ptr  <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      end else if (stage_dead || (stage_valid && io_enq_ready)) begin
        stage_valid <= 1'b0;
      end else begin
        stage_bits.uop.br_mask <= stage_bits.uop.br_mask & ~resolve;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (elig[i] && !io_req_ready[i])
          wait_cnt[i] <= (wait_cnt[i] == WAIT_MAX) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
        else
          wait_cnt[i] <= '0;
      end
    end
  end

  always_comb begin
    io_enq_bits             = stage_bits;
    io_enq_bits.uop.br_mask = stage_bits.uop.br_mask & ~resolve;
  end

  assign io_enq_valid = stage_valid && !stage_dead;
  assign io_grant_id  = stage_id;
  assign io_busy      = stage_valid;
endmodule
